// File: rtl/ring_osc_pkg.sv
`default_nettype none
// ring_osc_pkg -- shared state encoding and code-range helpers for the trim loop. (rev 1.0)
package ring_osc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_ADJUST  = 2'd2
  } state_t;

  function automatic int trim_max(input int nstages);
    return 2 * nstages;
  endfunction

  function automatic int clamp_code(input int code_in, input int max_code);
    return (code_in > max_code) ? max_code : code_in;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ring_osc_trim_decode.sv
`default_nettype none
// ring_osc_trim_decode -- trim code to thermometer bus, primary bits fill before secondary. (rev 1.0)
module ring_osc_trim_decode #(
  parameter int NSTAGES = 13,
  parameter int CODE_W  = $clog2(2*NSTAGES+1)
) (
  input  logic [CODE_W-1:0]    i_code,
  output logic [2*NSTAGES-1:0] o_trim
);

  // Bit k covers primary stage k for k < NSTAGES and secondary stage k-NSTAGES above that.
  for (genvar k = 0; k < 2*NSTAGES; k++) begin : g_bit
    assign o_trim[k] = (i_code > CODE_W'(k));
  end

endmodule
`default_nettype wire

// File: rtl/ring_osc_autotrim.sv
`default_nettype none
// ring_osc_autotrim -- measures divided oscillator per window and steps the trim code toward target. (rev 1.0)
module ring_osc_autotrim
  import ring_osc_pkg::*;
#(
  parameter int NSTAGES   = 13,
  parameter int CODE_W    = $clog2(2*NSTAGES+1),
  parameter int CNT_W     = 16,
  parameter int WIN_LOG2  = 10,
  parameter int TOL       = 2,
  parameter int LOCK_WINS = 4,
  parameter int INIT_CODE = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 manual,
  input  logic [CODE_W-1:0]    manual_code,
  input  logic [CNT_W-1:0]     target,
  input  logic                 osc_div,
  output logic [2*NSTAGES-1:0] trim,
  output logic [CODE_W-1:0]    code,
  output logic [CNT_W-1:0]     count_last,
  output logic                 meas_valid,
  output logic                 locked
);

  localparam int                C_MAX      = trim_max(NSTAGES);
  localparam int                INR_W      = $clog2(LOCK_WINS+1);
  localparam logic [CODE_W-1:0] c_max_code = CODE_W'(C_MAX);
  localparam logic [CODE_W-1:0] c_init     = CODE_W'(clamp_code(INIT_CODE, C_MAX));
  localparam logic [INR_W-1:0]  c_lock     = INR_W'(LOCK_WINS);
  localparam logic [INR_W-1:0]  c_lock_m1  = INR_W'(LOCK_WINS-1);
  localparam logic [CNT_W:0]    c_tol      = (CNT_W+1)'(TOL);

  state_t                r_state, w_state_next;
  logic                  r_sync1, r_sync2, r_sync_prev;
  logic [WIN_LOG2-1:0]   r_win;
  logic [CNT_W-1:0]      r_cnt, r_count_last;
  logic [CODE_W-1:0]     r_code, w_code_d, w_manual_clamped;
  logic [2*NSTAGES-1:0]  r_trim, w_trim_d;
  logic [INR_W-1:0]      r_inr, w_inr_d;
  logic                  r_locked, w_locked_d, r_meas_valid;
  logic                  w_run, w_rise, w_adjust, w_fast, w_slow;
  logic [CNT_W:0]        w_cnt_x, w_tgt_x;

  assign w_run    = enable && !manual;
  assign w_rise   = r_sync2 && !r_sync_prev;
  assign w_adjust = (r_state == ST_ADJUST) && w_run;

  // Data-only synchronizer plus edge register; no reset so the chain never depends on it.
  always_ff @(posedge clock) begin
    r_sync1     <= osc_div;
    r_sync2     <= r_sync1;
    r_sync_prev <= r_sync2;
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:    w_state_next = ST_MEASURE;
      ST_MEASURE: if (&r_win) w_state_next = ST_ADJUST;
      ST_ADJUST:  w_state_next = ST_MEASURE;
      default:    w_state_next = ST_IDLE;
    endcase
    if (!w_run) w_state_next = ST_IDLE;
  end

  // Counters run only while measuring, so every entry to MEASURE starts them from zero.
  always_ff @(posedge clock) begin
    if (reset || r_state != ST_MEASURE) begin
      r_win <= '0;
      r_cnt <= '0;
    end else begin
      r_win <= r_win + 1'b1;
      if (w_rise && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_cnt_x = {1'b0, r_cnt};
  assign w_tgt_x = {1'b0, target};
  assign w_fast  = w_cnt_x > (w_tgt_x + c_tol);
  assign w_slow  = (w_cnt_x + c_tol) < w_tgt_x;
  assign w_manual_clamped = CODE_W'(clamp_code(int'(manual_code), C_MAX));

  always_comb begin
    w_code_d   = r_code;
    w_inr_d    = r_inr;
    w_locked_d = r_locked;
    if (reset) begin
      w_code_d   = c_init;
      w_inr_d    = '0;
      w_locked_d = 1'b0;
    end else if (manual) begin
      w_code_d   = w_manual_clamped;
      w_inr_d    = '0;
      w_locked_d = 1'b0;
    end else if (w_adjust) begin
      if (w_fast || w_slow) begin
        w_inr_d    = '0;
        w_locked_d = 1'b0;
        if (w_fast && r_code != c_max_code) w_code_d = r_code + 1'b1;
        if (w_slow && r_code != '0)         w_code_d = r_code - 1'b1;
      end else if (r_inr >= c_lock_m1) begin
        w_inr_d    = c_lock;
        w_locked_d = 1'b1;
      end else begin
        w_inr_d = r_inr + 1'b1;
      end
    end
  end

  ring_osc_trim_decode #(
    .NSTAGES (NSTAGES),
    .CODE_W  (CODE_W)
  ) u_decode (
    .i_code (w_code_d),
    .o_trim (w_trim_d)
  );

  // Code and trim register together from the same next value, so trim never lags code.
  always_ff @(posedge clock) begin
    r_code   <= w_code_d;
    r_trim   <= w_trim_d;
    r_inr    <= w_inr_d;
    r_locked <= w_locked_d;
    if (reset) begin
      r_count_last <= '0;
      r_meas_valid <= 1'b0;
    end else begin
      r_meas_valid <= w_adjust;
      if (w_adjust) r_count_last <= r_cnt;
    end
  end

  assign trim       = r_trim;
  assign code       = r_code;
  assign count_last = r_count_last;
  assign meas_valid = r_meas_valid;
  assign locked     = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_ring_osc_autotrim.sv
`default_nettype none
// tb_ring_osc_autotrim -- directed checks of the trim loop with hand-computed expectations. (rev 1.0)
module tb_ring_osc_autotrim;

  localparam int NST   = 13;
  localparam int CW    = 5;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset, enable, manual, osc_div;
  logic [CW-1:0]    manual_code;
  logic [CNT_W-1:0] target;
  logic [2*NST-1:0] trim;
  logic [CW-1:0]    code;
  logic [CNT_W-1:0] count_last;
  logic             meas_valid, locked;

  int n_cmp = 0;
  int n_bad = 0;
  bit osc_on = 1'b0;
  int osc_ph = 0;

  always #5 clock = ~clock;

  ring_osc_autotrim #(
    .NSTAGES(NST), .CODE_W(CW), .CNT_W(CNT_W), .WIN_LOG2(6),
    .TOL(2), .LOCK_WINS(4), .INIT_CODE(12)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .manual(manual),
    .manual_code(manual_code), .target(target), .osc_div(osc_div),
    .trim(trim), .code(code), .count_last(count_last),
    .meas_valid(meas_valid), .locked(locked)
  );

  // Divided oscillator with an 8-clock period: 8 rising edges in any 64-cycle window.
  always @(negedge clock) begin
    if (osc_on) begin
      osc_ph  = (osc_ph + 1) % 8;
      osc_div = (osc_ph < 4);
    end else begin
      osc_div = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_meas(output int cyc);
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (meas_valid) break;
    end
    if (!meas_valid) chk("meas_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int cyc;
    int pulses;
    logic [31:0] exp_trim [2];
    exp_trim[0] = 32'h0001FFF;
    exp_trim[1] = 32'h0003FFF;

    reset = 1'b1; enable = 1'b0; manual = 1'b0; manual_code = '0;
    target = 16'd8; osc_div = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_code", 32'(code), 32'd12);
    chk("rst_trim", 32'(trim), 32'h0000FFF);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_meas_valid", 32'(meas_valid), 32'd0);
    chk("rst_count_last", 32'(count_last), 32'd0);

    reset = 1'b0; osc_on = 1'b1; enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_meas(cyc);
      chk("inrange_count", 32'(count_last), 32'd8);
      chk("inrange_code", 32'(code), 32'd12);
      chk("inrange_locked", 32'(locked), (i == 4) ? 32'd1 : 32'd0);
    end

    target = 16'd4;
    for (int i = 0; i < 2; i++) begin
      wait_meas(cyc);
      chk("fast_code", 32'(code), 32'(13 + i));
      chk("fast_trim", 32'(trim), exp_trim[i]);
      chk("fast_locked", 32'(locked), 32'd0);
    end
    repeat (12) wait_meas(cyc);
    chk("sat_hi_code", 32'(code), 32'd26);
    chk("sat_hi_trim", 32'(trim), 32'h3FFFFFF);
    wait_meas(cyc);
    chk("sat_hi_hold", 32'(code), 32'd26);
    chk("sat_hi_locked", 32'(locked), 32'd0);

    manual_code = 5'd5; manual = 1'b1;
    @(negedge clock);
    chk("man_code5", 32'(code), 32'd5);
    chk("man_trim5", 32'(trim), 32'h000001F);
    manual_code = 5'd30;
    @(negedge clock);
    chk("man_clamp", 32'(code), 32'd26);
    chk("man_locked", 32'(locked), 32'd0);
    pulses = 0;
    repeat (100) begin
      @(negedge clock);
      if (meas_valid) pulses++;
    end
    chk("man_idle_pulses", 32'(pulses), 32'd0);

    target = 16'd20; manual = 1'b0;
    wait_meas(cyc);
    chk("resume_code", 32'(code), 32'd25);

    manual_code = 5'd1; manual = 1'b1;
    @(negedge clock);
    chk("man_code1", 32'(code), 32'd1);
    manual = 1'b0;
    wait_meas(cyc);
    chk("slow_code", 32'(code), 32'd0);
    chk("slow_trim", 32'(trim), 32'd0);
    wait_meas(cyc);
    chk("sat_lo_code", 32'(code), 32'd0);
    chk("sat_lo_count", 32'(count_last), 32'd8);

    target = 16'd8;
    wait_meas(cyc);
    repeat (30) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midrst_code", 32'(code), 32'd12);
    chk("midrst_trim", 32'(trim), 32'h0000FFF);
    chk("midrst_count", 32'(count_last), 32'd0);
    chk("midrst_meas", 32'(meas_valid), 32'd0);
    wait_meas(cyc);
    chk("midrst_latency", 32'(cyc), 32'd66);
    chk("midrst_first_count", 32'(count_last), 32'd8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
